sprite_coord_fetcher: RTL

- Generalised, frame-synchronised replacement for the fixed six-coordinate VGA fetch sequencer.
- On each frame_start pulse, reads NUM_COORDS words from the VGA read port of the dual-port RAM at BASE_ADDR + k*STRIDE and captures them into shadow registers.
- Commits all shadow values atomically to the coords_flat output bus, so the VGA renderer never sees a half-updated coordinate set within a frame.
- Read latency, channel count, base address and stride are parameters.

---
 rtl/sprite_coord_fetcher.sv | 122 ++++++++++++
 1 files changed

// File: rtl/sprite_coord_fetcher.sv
// Frame-synchronised coordinate fetcher: reads NUM_COORDS words per frame into shadow
// registers, then commits them to coords_flat in one edge. Define COORD_CLAMP_EN to clamp X/Y at capture.
module sprite_coord_fetcher #(
  parameter int WIDTH        = 16,
  parameter int NUM_COORDS   = 6,
  parameter int BASE_ADDR    = 6000,
  parameter int STRIDE       = 4,
  parameter int READ_LATENCY = 1,
  parameter int H_RES        = 640,
  parameter int V_RES        = 480
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_start,
  input  logic [WIDTH-1:0]              mem_data,
  output logic [WIDTH-1:0]              mem_address,
  output logic [NUM_COORDS*WIDTH-1:0]   coords_flat,
  output logic                          busy,
  output logic                          update_done,
  output logic                          overrun
);

  localparam int CW = $clog2(NUM_COORDS + 1);

  if (NUM_COORDS < 1 || NUM_COORDS > 64 || READ_LATENCY < 1) begin : g_bad_cfg
    $error("sprite_coord_fetcher: NUM_COORDS must be 1..64 and READ_LATENCY >= 1");
  end
  if (H_RES < 1 || V_RES < 1) begin : g_bad_res
    $error("sprite_coord_fetcher: H_RES and V_RES must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, COMMIT} state_t;

  state_t            state, state_next;
  logic [CW-1:0]     issue_cnt, cap_cnt;
  logic [READ_LATENCY-1:0] cap_pipe;
  logic [WIDTH-1:0]  shadow [NUM_COORDS];
  logic [WIDTH-1:0]  cap_value;
  logic              cap_fire, issue_last, cap_last;

  // Capture timing follows the issue slots through a delay line, independent of FSM state.
  always_comb begin
    cap_fire   = cap_pipe[READ_LATENCY-1];
    issue_last = (issue_cnt == CW'(NUM_COORDS - 1));
    cap_last   = cap_fire && (cap_cnt == CW'(NUM_COORDS - 1));
  end

  always_comb begin
    cap_value = mem_data;
`ifdef COORD_CLAMP_EN
    if (!cap_cnt[0]) begin
      if (mem_data > WIDTH'(H_RES - 1)) cap_value = WIDTH'(H_RES - 1);
    end else begin
      if (mem_data > WIDTH'(V_RES - 1)) cap_value = WIDTH'(V_RES - 1);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_start) state_next = ISSUE;
      ISSUE:   if (issue_last)  state_next = DRAIN;
      DRAIN:   if (cap_last)    state_next = COMMIT;
      COMMIT:                   state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_address <= WIDTH'(BASE_ADDR);
      issue_cnt   <= '0;
      cap_cnt     <= '0;
      cap_pipe    <= '0;
      coords_flat <= '0;
      update_done <= 1'b0;
      overrun     <= 1'b0;
      for (int unsigned i = 0; i < NUM_COORDS; i++) shadow[i] <= '0;
    end else begin
      update_done <= (state == COMMIT);
      if (frame_start && state != IDLE) overrun <= 1'b1;
      cap_pipe <= READ_LATENCY'({cap_pipe, state == ISSUE});

      case (state)
        IDLE: begin
          mem_address <= WIDTH'(BASE_ADDR);
          if (frame_start) begin
            issue_cnt <= '0;
            cap_cnt   <= '0;
          end
        end
        ISSUE: begin
          issue_cnt <= issue_cnt + CW'(1);
          if (issue_last) mem_address <= WIDTH'(BASE_ADDR);
          else            mem_address <= mem_address + WIDTH'(STRIDE);
        end
        default: ;
      endcase

      if (cap_fire) begin
        for (int unsigned i = 0; i < NUM_COORDS; i++)
          if (cap_cnt == CW'(i)) shadow[i] <= cap_value;
        cap_cnt <= cap_cnt + CW'(1);
      end

      if (state == COMMIT)
        for (int unsigned i = 0; i < NUM_COORDS; i++)
          coords_flat[i*WIDTH +: WIDTH] <= shadow[i];
    end
  end

endmodule
